// File: rtl/xoodoo_squeeze_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xoodoo_squeeze_ctrl: streams the two-share Xoodoo state out word by word, |
// | trimming the final word; optional remasking under macro REMASK_EN.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module xoodoo_squeeze_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  word_index_o,
  input  logic [63:0] word_sh_i,
  input  logic [31:0] rnd_i,
  output logic [63:0] dout_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic        dout_last_o,
  output logic [2:0]  dout_bytes_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0]  state;
  logic [5:0]  len;
  logic [3:0]  words;
  logic [3:0]  rd_cnt;
  logic [5:0]  len_clamp;
  logic [6:0]  len_plus3;
  logic        load;
  logic        hshake;
  logic        final_word;
  logic [2:0]  nbytes;
  logic [31:0] byte_mask;
  logic [31:0] sh0;
  logic [31:0] sh1;

`ifdef REMASK_EN
  // Same mask on both shares keeps share0 ^ share1 unchanged.
  assign sh0 = word_sh_i[63:32] ^ rnd_i;
  assign sh1 = word_sh_i[31:0]  ^ rnd_i;
`else
  logic unused_rnd;
  assign unused_rnd = ^rnd_i;
  assign sh0 = word_sh_i[63:32];
  assign sh1 = word_sh_i[31:0];
`endif

  always_comb begin
    len_clamp  = (len_i > 6'd48) ? 6'd48 : len_i;
    len_plus3  = {1'b0, len_clamp} + 7'd3;
    load       = (state == STREAM) && (!dout_valid_o || dout_ready_i) && (rd_cnt < words);
    hshake     = dout_valid_o && dout_ready_i;
    final_word = (rd_cnt == words - 4'd1);
    nbytes     = (final_word && (len[1:0] != 2'b00)) ? {1'b0, len[1:0]} : 3'd4;
    byte_mask  = '0;
    for (int k = 0; k < 4; k++) begin
      byte_mask[8*k +: 8] = (3'(k) < nbytes) ? 8'hFF : 8'h00;
    end
  end

  // Index parks at 0 once the requested words are read so it never reads 12.
  assign word_index_o = ((state == STREAM) && (rd_cnt < words)) ? rd_cnt : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      words        <= '0;
      rd_cnt       <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      dout_last_o  <= 1'b0;
      dout_bytes_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            len    <= len_clamp;
            words  <= len_plus3[5:2];
            rd_cnt <= '0;
            busy_o <= 1'b1;
            state  <= (len_clamp == 6'd0) ? FLUSH : STREAM;
          end
        end
        STREAM: begin
          if (load) begin
            rd_cnt       <= rd_cnt + 4'd1;
            dout_valid_o <= 1'b1;
            dout_last_o  <= final_word;
            dout_bytes_o <= nbytes;
            dout_o       <= {sh0 & byte_mask, sh1 & byte_mask};
          end else if (hshake) begin
            dout_valid_o <= 1'b0;
            dout_last_o  <= 1'b0;
          end
          if (hshake && dout_last_o) begin
            state  <= FLUSH;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        FLUSH: begin
          // Zero-length squeezes arrive here with done_o low and spend one extra cycle.
          if (done_o) begin
            done_o <= 1'b0;
            state  <= IDLE;
          end else begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xoodoo_squeeze_ctrl.sv
`default_nettype none
// Bench for xoodoo_squeeze_ctrl: model-driven expected word queue plus literal pins.
module tb_xoodoo_squeeze_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  len_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  word_index_o;
  logic [63:0] word_sh_i;
  logic [31:0] rnd_i;
  logic [63:0] dout_o;
  logic        dout_valid_o;
  logic        dout_ready_i = 1'b0;
  logic        dout_last_o;
  logic [2:0]  dout_bytes_o;

  logic [31:0] pat0 = '0;
  logic [31:0] pat1 = '0;

  xoodoo_squeeze_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .word_index_o(word_index_o),
    .word_sh_i(word_sh_i), .rnd_i(rnd_i), .dout_o(dout_o),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .dout_last_o(dout_last_o), .dout_bytes_o(dout_bytes_o)
  );

  always #5 clk = ~clk;

  // State register model: word i = {pat0 ^ i, A5A5A5A5 ^ pat1 ^ i}
  assign word_sh_i = {pat0 ^ {28'h0, word_index_o},
                      32'hA5A5A5A5 ^ pat1 ^ {28'h0, word_index_o}};
`ifdef REMASK_EN
  assign rnd_i = 32'hFFFFFFFF;
  localparam logic [31:0] MODEL_RND = 32'hFFFFFFFF;
`else
  assign rnd_i = 32'h3C3C3C3C;
  localparam logic [31:0] MODEL_RND = 32'h0;
`endif

  typedef struct {
    logic [63:0] d;
    logic [2:0]  b;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] got_q[$];
  logic [2:0]  gotb_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  bit checking = 0;
  int done_cnt, done_rel, first_valid_rel, last_hs_rel;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      int rel;
      rel = cyc - t0 + 1;
      chk("index_range", 64'(word_index_o > 4'd11), 64'd0);
      chk("busy", 64'(busy_o), 64'((done_cnt == 0) && !done_o));
      if (done_o) begin
        done_cnt++;
        done_rel = rel;
      end
      if (dout_valid_o) begin
        if (first_valid_rel < 0) first_valid_rel = rel;
        if (exp_q.size() == 0) begin
          chk("extra_word", 64'd1, 64'd0);
        end else begin
          chk("dout", dout_o, exp_q[0].d);
          chk("bytes", 64'(dout_bytes_o), 64'(exp_q[0].b));
          chk("last", 64'(dout_last_o), 64'(exp_q[0].l));
          if (dout_ready_i) begin
            if (exp_q[0].l) last_hs_rel = rel;
            got_q.push_back(dout_o);
            gotb_q.push_back(dout_bytes_o);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Expected words from the byte-level rules: L bytes, 4 per word, tail trimmed.
  function automatic int build_model(input int len);
    int l, n, nb;
    logic [31:0] s0, s1, m;
    exp_t e;
    l = (len > 48) ? 48 : len;
    n = (l + 3) / 4;
    for (int i = 0; i < n; i++) begin
      nb = (i == n - 1) ? (l - 4 * i) : 4;
      m  = (nb >= 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nb)) - 32'h1);
      s0 = (pat0 ^ 32'(i)) ^ MODEL_RND;
      s1 = (32'hA5A5A5A5 ^ pat1 ^ 32'(i)) ^ MODEL_RND;
      e.d = {s0 & m, s1 & m};
      e.b = 3'(nb);
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
    return n;
  endfunction

  // mode 0: ready held high; mode 1: ready toggles. abort_after>0 resets mid-stream.
  task automatic run(input int len, input int mode, input int stray_rel, input int abort_after,
                     output int n_words);
    bit aborted;
    aborted = 0;
    exp_q.delete(); got_q.delete(); gotb_q.delete();
    done_cnt = 0; done_rel = -1; first_valid_rel = -1; last_hs_rel = -1;
    n_words = build_model(len);
    @(posedge clk); #1;
    start_i = 1'b1; len_i = 6'(len);
    @(posedge clk); #1;
    start_i = 1'b0; t0 = cyc; checking = 1;
    for (int c = 1; c < 200; c++) begin
      dout_ready_i = (mode == 0) ? 1'b1 : c[0];
      start_i = (c == stray_rel);
      if (c == stray_rel) len_i = 6'd0;
      if (abort_after > 0 && got_q.size() == abort_after) begin
        rst = 1'b1;
        aborted = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        checking = 0;
        break;
      end
      @(posedge clk); #1;
      if (done_cnt > 0 && c > done_rel + 2) break;
    end
    start_i = 1'b0;
    checking = 0;
    if (aborted) begin
      @(negedge clk);
      chk("abort_dout", dout_o, 64'd0);
      chk("abort_flags", {59'd0, busy_o, done_o, dout_valid_o, dout_last_o, 1'b0},
          64'd0);
      chk("abort_bytes_idx", {57'd0, dout_bytes_o, word_index_o}, 64'd0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("abort_no_done", {62'd0, done_o, dout_valid_o}, 64'd0);
      end
    end else begin
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("words_left", 64'(exp_q.size()), 64'd0);
      chk("words_got", 64'(got_q.size()), 64'(n_words));
      if (mode == 0)
        chk("done_cycle", 64'(done_rel), 64'((n_words == 0) ? 2 : n_words + 2));
      else
        chk("done_after_last", 64'(done_rel), 64'(last_hs_rel + 1));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dout", dout_o, 64'd0);
    chk("rst_flags", {60'd0, busy_o, done_o, dout_valid_o, dout_last_o}, 64'd0);
    chk("rst_bytes_idx", {57'd0, dout_bytes_o, word_index_o}, 64'd0);

    // 24 bytes, full words only
    run(24, 0, 0, 0, n);
    chk("l24_first_valid", 64'(first_valid_rel), 64'd2);
    chk("l24_done", 64'(done_rel), 64'd8);
`ifdef REMASK_EN
    chk("l24_w0", got_q[0], 64'hFFFFFFFF_5A5A5A5A);
`else
    chk("l24_w0", got_q[0], 64'h00000000_A5A5A5A5);
`endif
    chk("l24_unmasked", 64'(got_q[0][63:32] ^ got_q[0][31:0]), 64'hA5A5A5A5);

    // 5 bytes: one full word plus a 1-byte tail
    run(5, 0, 0, 0, n);
    chk("l5_done", 64'(done_rel), 64'd4);
    chk("l5_bytes", 64'(gotb_q[1]), 64'd1);
`ifdef REMASK_EN
    chk("l5_w1", got_q[1], 64'h000000FE_0000005B);
`else
    chk("l5_w1", got_q[1], 64'h00000001_000000A4);
`endif

    // 48 bytes with backpressure and a stray start mid-run
    pat0 = 32'h12345678; pat1 = 32'h0F0F0F0F;
    run(48, 1, 5, 0, n);
    chk("l48_words", 64'(n), 64'd12);

    // zero length
    pat0 = '0; pat1 = '0;
    run(0, 0, 0, 0, n);
    chk("l0_done", 64'(done_rel), 64'd2);
    chk("l0_no_valid", 64'(first_valid_rel), 64'hFFFFFFFF_FFFFFFFF);

    // length above 48 clamps
    run(63, 0, 0, 0, n);
    chk("l63_done", 64'(done_rel), 64'd14);

    // reset after three words, then a fresh squeeze
    run(48, 0, 0, 3, n);
    pat0 = 32'hDEADBEEF;
    run(7, 0, 0, 0, n);
    chk("l7_tail_bytes", 64'(gotb_q[1]), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
